alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-driven controller for the 4-bit-operand ALU and its 8-bit accumulator register. It accepts one command per handshake: an ALU function, an operand A, a repeat count and an optional clear. It then drives the function select, operand and register enable for exactly the requested number of accumulate cycles. When the run ends it captures the accumulator value and pulses `done`. It sits between a host (switch/key front-end or a test FSM) and the ALU datapath, replacing manual key-clocking of the register.

## Interface
Parameters:
- `CW`, 4, width of repeat count (max run length 2^CW−1)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  host offers a command
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`
- `cmd_func`  in  3  ALU function code 0–7
- `cmd_a`  in  4  operand A
- `cmd_count`  in  CW  number of accumulate cycles
- `cmd_clear`  in  1  clear the accumulator before running
- `abort`  in  1  stop the run early (RUN state only)
- `alu_func`  out  3  function select to the ALU (latched from the command)
- `alu_a`  out  4  operand A to the ALU (latched from the command)
- `acc_en`  out  1  load enable to the accumulator register
- `acc_clr`  out  1  clear strobe to the accumulator register
- `acc_q`  in  8  accumulator register output (B = `acc_q[3:0]`)
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  valid with `done`; high if the run was aborted
- `result`  out  8  accumulator value captured in DONE; held until the next DONE or reset

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- **IDLE.** `cmd_ready` is 1. On accept:
  - latch `cmd_func` into `alu_func` and `cmd_a` into `alu_a`;
  - load `cmd_count` into the remaining counter `rem`;
  - go to CLEAR if `cmd_clear` is 1;
  - otherwise go to RUN if `cmd_count` ≠ 0, else go to DONE.
- **CLEAR.** One cycle with `acc_clr` = 1. Then go to RUN if `rem` ≠ 0, else go to DONE.
- **RUN.**
  - `acc_en = ~abort`.
  - Each cycle with `acc_en` high decrements `rem`.
  - Go to DONE when `rem == 1` or when `abort` is 1.
  - `aborted` is set if `abort` is seen in any RUN cycle, including the last one.
- **DONE.**
  - `result <= acc_q`.
  - `done` = 1 for this one cycle.
  - Return to IDLE.
- `alu_func` and `alu_a` are stable from the cycle after accept until the next accept.
- `acc_en` and `acc_clr` are never both high.
- `acc_en` is never high outside RUN.
- `abort` is ignored outside RUN.
- `cmd_*` inputs are ignored when `cmd_ready` is 0.
- **Reset** (any state, including mid-run):
  - next state is IDLE;
  - `alu_func`, `alu_a`, `rem`, `result` and `aborted` go to 0;
  - `acc_en`, `acc_clr`, `busy` and `done` go to 0;
  - no `done` pulse is issued for the killed run.
  - `cmd_ready` is 0 while `reset` is high and 1 in the first cycle after reset releases.
- Arithmetic: `rem` is CW bits wide. It is never decremented at 0, so there is no wrap.

## Timing
- Accept occurs in cycle T.
- With clear:
  - CLEAR in T+1;
  - RUN in T+2 … T+1+N;
  - DONE in T+2+N.
- Without clear:
  - RUN in T+1 … T+N;
  - DONE in T+N+1.
- N = 0 gives DONE at T+2 (with clear) or T+1 (without clear).
- `acc_q` in the DONE cycle already reflects the last RUN load, so `result` equals the final accumulator value.
- Back-to-back throughput: the earliest next accept is the IDLE cycle after DONE.
- `busy` and `cmd_ready` are combinational decodes of the state register. All other outputs are registered or decoded from state only.
- Exception: `acc_en` is combinational from `abort`.

## Structure
- Package `alu_seq_pkg` contains:
  - the state enum (IDLE, CLEAR, RUN, DONE);
  - the ALU function codes: 0 A+1, 1 A+B ripple, 2 A+B, 3 {A|B, A^B}, 4 reduction OR, 5 B<<A, 6 B>>A, 7 A*B.
- A single module is sufficient; no sub-module is needed.
- The bench instantiates the existing ALU datapath, or an equivalent model, with `acc_en` and `acc_clr` driving the 8-bit register.

## Test plan
- **Reset behaviour.** Hold `reset` 3 cycles → all outputs 0; `cmd_ready` = 1 in the first cycle after release.
- **Repeated add.** func 2, a = 3, count = 4, clear = 1 → `acc_clr` at T+1; `acc_en` high T+2…T+5; accumulator 0→3→6→9→12; `done` at T+6 with `result` = 0x0C and `aborted` = 0.
- **OR/XOR, no clear.** After the previous command (accumulator = 0x0C), func 3, a = 5, count = 1, clear = 0 → single load; `result` = {5|C, 5^C} = 0xD9.
- **Zero count.** func 7, count = 0, clear = 1 → CLEAR, then DONE at T+2; `acc_en` never asserted; `result` = 0x00.
- **Abort.** func 0, a = 7, count = 10, clear = 1; `abort` asserted in the 3rd RUN cycle → exactly 2 loads (accumulator 8 after each); `done` the next cycle with `aborted` = 1 and `result` = 0x08.
- **Reset mid-run.** Assert `reset` during RUN → IDLE next cycle; `acc_en` = 0; no `done` pulse; `result` = 0. A new command accepted afterward runs normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ALU function codes (B is the low nibble of the accumulator)
  localparam logic [2:0] FN_INC       = 3'd0; // A+1
  localparam logic [2:0] FN_ADD_RIPPLE = 3'd1; // A+B via ripple adder
  localparam logic [2:0] FN_ADD       = 3'd2; // A+B
  localparam logic [2:0] FN_ORXOR     = 3'd3; // {A|B, A^B}
  localparam logic [2:0] FN_REDOR     = 3'd4; // reduction OR
  localparam logic [2:0] FN_SHL       = 3'd5; // B<<A
  localparam logic [2:0] FN_SHR       = 3'd6; // B>>A
  localparam logic [2:0] FN_MUL       = 3'd7; // A*B

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Host command handshake plus ALU/accumulator control bus.
interface alu_op_sequencer_if #(
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_func;
  logic [3:0]    cmd_a;
  logic [CW-1:0] cmd_count;
  logic          cmd_clear;
  logic          abort;
  logic [2:0]    alu_func;
  logic [3:0]    alu_a;
  logic          acc_en;
  logic          acc_clr;
  logic [7:0]    acc_q;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [7:0]    result;

  // Host / datapath side
  modport master (
    output cmd_valid, cmd_func, cmd_a, cmd_count, cmd_clear, abort, acc_q,
    input  cmd_ready, alu_func, alu_a, acc_en, acc_clr, busy, done, aborted, result
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_func, cmd_a, cmd_count, cmd_clear, abort, acc_q,
    output cmd_ready, alu_func, alu_a, acc_en, acc_clr, busy, done, aborted, result
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs one ALU command for a counted number of accumulate cycles,
// then captures the accumulator and pulses done.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_op_sequencer_if.slave bus
);

  state_t        state;
  logic [CW-1:0] rem;
  logic [2:0]    func_q;
  logic [3:0]    a_q;
  logic          abt_q;
  logic [7:0]    res_q;
  logic          accept;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  // Control FSM: command latch, remaining-count tracking, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rem    <= '0;
      func_q <= '0;
      a_q    <= '0;
      abt_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            func_q <= bus.cmd_func;
            a_q    <= bus.cmd_a;
            rem    <= bus.cmd_count;
            abt_q  <= 1'b0;
            if (bus.cmd_clear)            state <= ST_CLEAR;
            else if (bus.cmd_count != '0) state <= ST_RUN;
            else                          state <= ST_DONE;
          end
        end
        ST_CLEAR: begin
          state <= (rem != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          // rem only reaches RUN non-zero, but guard anyway so it cannot wrap
          if (!bus.abort && rem != '0) rem <= rem - CW'(1);
          if (bus.abort) abt_q <= 1'b1;
          if (bus.abort || rem == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          // acc_q already holds the last RUN load here
          res_q <= bus.acc_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake is blocked while reset is held, even if state is still stale
  assign bus.cmd_ready = (state == ST_IDLE) & ~reset;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.acc_clr   = (state == ST_CLEAR);
  // Load enable follows abort combinationally so an aborting cycle never loads
  assign bus.acc_en    = (state == ST_RUN) & ~bus.abort;
  assign bus.done      = (state == ST_DONE);
  assign bus.aborted   = abt_q;
  assign bus.result    = res_q;
  assign bus.alu_func  = func_q;
  assign bus.alu_a     = a_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU + accumulator.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] acc;
  logic [7:0] alu_y;

  alu_op_sequencer_if #(.CW(4)) bus();

  alu_op_sequencer #(.CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model, B is the low accumulator nibble
  always_comb begin
    logic [3:0] b;
    b = acc[3:0];
    alu_y = 8'h00;
    case (bus.alu_func)
      3'd0: alu_y = {4'h0, bus.alu_a} + 8'd1;
      3'd1: alu_y = {4'h0, bus.alu_a} + {4'h0, b};
      3'd2: alu_y = {4'h0, bus.alu_a} + {4'h0, b};
      3'd3: alu_y = {bus.alu_a | b, bus.alu_a ^ b};
      3'd4: alu_y = {7'h00, |{bus.alu_a, b}};
      3'd5: alu_y = {4'h0, b} << bus.alu_a;
      3'd6: alu_y = {4'h0, b} >> bus.alu_a;
      default: alu_y = {4'h0, bus.alu_a} * {4'h0, b};
    endcase
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset)            acc <= 8'h00;
    else if (bus.acc_clr) acc <= 8'h00;
    else if (bus.acc_en)  acc <= alu_y;
  end
  assign bus.acc_q = acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and trace the run cycle by cycle (k = cycles after accept)
  task automatic run_cmd(input string tag, input logic [2:0] f, input logic [3:0] a,
                         input logic [3:0] n, input logic clr, input int abort_at,
                         input int exp_clr, input int exp_first, input int exp_en,
                         input int exp_done, input logic exp_abt, input logic [7:0] exp_res);
    int   clr_at, en_first, en_n, done_at, both, outside;
    logic abt_s;
    logic [2:0] f_done;
    logic [3:0] a_done;
    clr_at = -1; en_first = -1; en_n = 0; done_at = -1; both = 0; outside = 0;
    abt_s = 1'b0; f_done = '0; a_done = '0;
    chk({tag, " ready"}, bus.cmd_ready, 1'b1);
    bus.cmd_func = f; bus.cmd_a = a; bus.cmd_count = n; bus.cmd_clear = clr;
    bus.cmd_valid = 1'b1;
    step();
    // Garbage on the command port while busy must be ignored
    bus.cmd_func = ~f; bus.cmd_a = ~a; bus.cmd_count = 4'hF; bus.cmd_clear = 1'b1;
    chk({tag, " func"}, bus.alu_func, f);
    chk({tag, " a"}, bus.alu_a, a);
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      bus.abort = (k == abort_at);
      #1;
      if (bus.acc_clr && clr_at < 0) clr_at = k;
      if (bus.acc_en) begin
        en_n++;
        if (en_first < 0) en_first = k;
      end
      if (bus.acc_en && bus.acc_clr) both++;
      if (bus.acc_en && (bus.done || !bus.busy)) outside++;
      if (bus.done) begin
        done_at = k; abt_s = bus.aborted; f_done = bus.alu_func; a_done = bus.alu_a;
      end
      step();
    end
    bus.abort = 1'b0;
    bus.cmd_valid = 1'b0;
    chk({tag, " clr_cyc"}, clr_at, exp_clr);
    chk({tag, " en_first"}, en_first, exp_first);
    chk({tag, " en_cnt"}, en_n, exp_en);
    chk({tag, " done_cyc"}, done_at, exp_done);
    chk({tag, " aborted"}, abt_s, exp_abt);
    chk({tag, " en_clr_both"}, both, 0);
    chk({tag, " en_outside"}, outside, 0);
    chk({tag, " func_hold"}, f_done, f);
    chk({tag, " a_hold"}, a_done, a);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    int dn;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_func = '0; bus.cmd_a = '0;
    bus.cmd_count = '0; bus.cmd_clear = 1'b0; bus.abort = 1'b0;

    repeat (3) step();
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst acc_en", bus.acc_en, 1'b0);
    chk("rst acc_clr", bus.acc_clr, 1'b0);
    chk("rst func", bus.alu_func, 3'd0);
    chk("rst a", bus.alu_a, 4'd0);
    chk("rst result", bus.result, 8'h00);
    chk("rst aborted", bus.aborted, 1'b0);
    chk("rst ready_in_reset", bus.cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst ready_after", bus.cmd_ready, 1'b1);

    //      tag       f     a     n      clr  ab  clr fst en dn abt  res
    run_cmd("add",    3'd2, 4'd3, 4'd4,  1'b1, 0, 1,  2, 4, 6, 1'b0, 8'h0C);
    run_cmd("orxor",  3'd3, 4'd5, 4'd1,  1'b0, 0, -1, 1, 1, 2, 1'b0, 8'hD9);
    run_cmd("zero",   3'd7, 4'd9, 4'd0,  1'b1, 0, 1, -1, 0, 2, 1'b0, 8'h00);
    run_cmd("abort",  3'd0, 4'd7, 4'd10, 1'b1, 4, 1,  2, 2, 5, 1'b1, 8'h08);
    run_cmd("shr",    3'd6, 4'd1, 4'd2,  1'b0, 0, -1, 1, 2, 3, 1'b0, 8'h02);
    run_cmd("zero_nc",3'd1, 4'd0, 4'd0,  1'b0, 0, -1, -1, 0, 1, 1'b0, 8'h02);
    run_cmd("ab_last",3'd2, 4'd1, 4'd2,  1'b1, 3, 1,  2, 1, 4, 1'b1, 8'h01);

    // Reset in the middle of a run
    bus.cmd_func = 3'd2; bus.cmd_a = 4'd1; bus.cmd_count = 4'd8; bus.cmd_clear = 1'b1;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step(); step();
    chk("mid in_run", bus.acc_en, 1'b1);
    reset = 1'b1;
    step();
    dn = 0;
    chk("mid busy", bus.busy, 1'b0);
    chk("mid acc_en", bus.acc_en, 1'b0);
    chk("mid result", bus.result, 8'h00);
    chk("mid aborted", bus.aborted, 1'b0);
    chk("mid func", bus.alu_func, 3'd0);
    if (bus.done) dn++;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.done) dn++;
      step();
    end
    chk("mid no_done", dn, 0);
    run_cmd("post",   3'd2, 4'd1, 4'd2,  1'b1, 0, 1,  2, 2, 4, 1'b0, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
